// File: rtl/mm_pkg.sv
// Shared encodings for the mm_stage_bus memory stage: access modes, FSM states,
// and per-mode size/legality/signedness helpers.
package mm_pkg;

    localparam logic [2:0] MODE_B  = 3'd0;
    localparam logic [2:0] MODE_H  = 3'd1;
    localparam logic [2:0] MODE_W  = 3'd2;
    localparam logic [2:0] MODE_D  = 3'd3;
    localparam logic [2:0] MODE_BU = 3'd4;
    localparam logic [2:0] MODE_HU = 3'd5;
    localparam logic [2:0] MODE_WU = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mm_state_t;

    function automatic logic [3:0] access_bytes(input logic [2:0] mode);
        case (mode)
            MODE_B, MODE_BU: access_bytes = 4'd1;
            MODE_H, MODE_HU: access_bytes = 4'd2;
            MODE_W, MODE_WU: access_bytes = 4'd4;
            MODE_D:          access_bytes = 4'd8;
            default:         access_bytes = 4'd0;
        endcase
    endfunction

    // D and WU only exist on a 64-bit datapath.
    function automatic logic mode_legal(input logic [2:0] mode, input int dwidth);
        case (mode)
            MODE_D, MODE_WU:                         mode_legal = (dwidth == 64);
            MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU: mode_legal = 1'b1;
            default:                                 mode_legal = 1'b0;
        endcase
    endfunction

    function automatic logic mode_signed(input logic [2:0] mode);
        case (mode)
            MODE_B, MODE_H, MODE_W: mode_signed = 1'b1;
            default:                mode_signed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mm_lane_align.sv
// Byte-lane steering for the memory stage: store byte enables and shifted write
// data, plus load lane extraction with sign or zero extension.
module mm_lane_align
    import mm_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [2:0]         mode,
    input  logic [2:0]         offset,
    input  logic [width-1:0]   st_data,
    input  logic [width-1:0]   ld_beat,
    output logic [width/8-1:0] be,
    output logic [width-1:0]   wdata,
    output logic [width-1:0]   ld_value
);

    localparam int NB = width / 8;

    logic [3:0]       nbytes;
    logic [5:0]       bit_shift;
    logic [NB-1:0]    be_base;
    logic [width-1:0] st_lanes;
    logic [width-1:0] ld_shift;
    logic             sign_bit;

    always_comb begin
        nbytes    = access_bytes(mode);
        bit_shift = {offset, 3'b000};
        be_base   = '0;
        st_lanes  = '0;
        ld_value  = '0;
        for (int i = 0; i < NB; i++) begin
            be_base[i] = (i < int'(nbytes));
        end
        for (int i = 0; i < width; i++) begin
            st_lanes[i] = (i < 8 * int'(nbytes)) ? st_data[i] : 1'b0;
        end
        be       = be_base << offset;
        wdata    = st_lanes << bit_shift;
        ld_shift = ld_beat >> bit_shift;
        case (nbytes)
            4'd1:    sign_bit = ld_shift[7];
            4'd2:    sign_bit = ld_shift[15];
            default: sign_bit = ld_shift[31];
        endcase
        sign_bit = sign_bit & mode_signed(mode);
        // A full-width access never reaches the fill branch, so it is left unextended.
        for (int i = 0; i < width; i++) begin
            ld_value[i] = (i < 8 * int'(nbytes)) ? ld_shift[i] : sign_bit;
        end
    end

endmodule

// File: rtl/mm_stage_bus.sv
// Memory stage driving an external request/grant/response bus with variable latency.
// Build macro MM_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
//
// state   | meaning
// IDLE    | accept passthrough ops or issue a legal memory op
// REQ     | memReq held with stable address/data/BE until memGnt
// RESP    | load granted, waiting for memRValid
module mm_stage_bus
    import mm_pkg::*;
#(
    parameter int width    = 32,
    parameter int adrWidth = 24,
    parameter int rsWidth  = 5
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                stallIn,
    input  logic                read,
    input  logic                write,
    input  logic                noMEM,
    input  logic [width-1:0]    data,
    input  logic [width-1:0]    address,
    input  logic [2:0]          addressMode,
    input  logic [rsWidth-1:0]  rd,
    output logic                memReq,
    output logic                memWe,
    output logic [adrWidth-1:0] memAddr,
    output logic [width-1:0]    memWData,
    output logic [width/8-1:0]  memBe,
    input  logic                memGnt,
    input  logic                memRValid,
    input  logic [width-1:0]    memRData,
    output logic [rsWidth-1:0]  rdOut,
    output logic [width-1:0]    dataOut,
    output logic                WEOut,
    output logic                stallOut
`ifdef MM_MISALIGN_TRAP_EN
    ,
    output logic                misalignOut
`endif
);

    localparam int NB = width / 8;
    localparam int OB = $clog2(NB);

    mm_state_t state, state_nxt;

    logic                mem_op;
    logic                mode_ok;
    logic                op_ok;
    logic                issue;
    logic                op_done;
    logic [2:0]          raw_ofs;
    logic [2:0]          size_mask;
    logic [2:0]          aligned_ofs;
    logic [2:0]          ofs_q;
    logic [2:0]          mode_q;
    logic [2:0]          lane_mode;
    logic [2:0]          lane_ofs;
    logic [rsWidth-1:0]  rd_q;
    logic [adrWidth-1:0] aligned_addr;
    logic [NB-1:0]       lane_be;
    logic [width-1:0]    lane_wdata;
    logic [width-1:0]    lane_ld;

    assign mem_op       = read | write;
    assign mode_ok      = mode_legal(addressMode, width);
    assign raw_ofs      = 3'(address[OB-1:0]);
    assign size_mask    = 3'(access_bytes(addressMode) - 4'd1);
    assign aligned_ofs  = raw_ofs & ~size_mask;
    assign aligned_addr = {address[adrWidth-1:OB], {OB{1'b0}}};

    if (width > adrWidth) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^address[width-1:adrWidth];
    end

`ifdef MM_MISALIGN_TRAP_EN
    logic misaligned;
    logic trap;
    assign misaligned = |(raw_ofs & size_mask);
    assign op_ok      = mem_op & mode_ok & ~misaligned;
    assign trap       = (state == ST_IDLE) & ~stallIn & mem_op & mode_ok & misaligned;
`else
    assign op_ok      = mem_op & mode_ok;
`endif

    assign issue = (state == ST_IDLE) & ~stallIn & op_ok;

    // Store lanes are built from the live inputs at issue; loads extract with the captured op.
    assign lane_mode = (state == ST_IDLE) ? addressMode : mode_q;
    assign lane_ofs  = (state == ST_IDLE) ? aligned_ofs : ofs_q;

    mm_lane_align #(.width(width)) u_lane (
        .mode     (lane_mode),
        .offset   (lane_ofs),
        .st_data  (data),
        .ld_beat  (memRData),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .ld_value (lane_ld)
    );

    always_comb begin
        state_nxt = state;
        op_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (memGnt) begin
                    if (memWe) begin
                        state_nxt = ST_IDLE;
                        op_done   = 1'b1;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (memRValid) begin
                    state_nxt = ST_IDLE;
                    op_done   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stallOut = stallIn | ((state == ST_IDLE) ? op_ok : ~op_done);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= ST_IDLE;
            rdOut    <= '0;
            dataOut  <= '0;
            WEOut    <= 1'b0;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memBe    <= '0;
            memWData <= '0;
            rd_q     <= '0;
            mode_q   <= '0;
            ofs_q    <= '0;
`ifdef MM_MISALIGN_TRAP_EN
            misalignOut <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            rdOut   <= '0;
            dataOut <= '0;
            WEOut   <= 1'b0;
`ifdef MM_MISALIGN_TRAP_EN
            misalignOut <= trap;
`endif
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        memReq   <= 1'b1;
                        memWe    <= write;
                        memAddr  <= aligned_addr;
                        memBe    <= lane_be;
                        memWData <= write ? lane_wdata : '0;
                        rd_q     <= rd;
                        mode_q   <= addressMode;
                        ofs_q    <= aligned_ofs;
                    end else if (!stallIn && !mem_op) begin
                        rdOut   <= rd;
                        dataOut <= data;
                        WEOut   <= noMEM;
                    end
                end
                ST_REQ: begin
                    if (memGnt) memReq <= 1'b0;
                end
                ST_RESP: begin
                    if (memRValid) begin
                        rdOut   <= rd_q;
                        dataOut <= lane_ld;
                        WEOut   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mm_stage_bus.md
Name: mm_stage_bus

Overview:
Next-generation memory stage. It replaces the internal RAM array with an external request/grant/response memory bus that tolerates variable latency. The datapath is parametrised to 32 or 64 bits. The block generates per-byte lane enables on stores and extracts and extends load data. It holds the upstream pipeline through stallOut while a memory operation is outstanding, then presents a registered writeback (rdOut/dataOut/WEOut) to the register file.

Parameters:
width, 32, datapath width; legal values 32 or 64.
adrWidth, 24, physical byte-address width on the memory bus.
rsWidth, 5, register specifier width.

Ports:
clk  in  1  clock
rstN  in  1  asynchronous active-low reset
stallIn  in  1  upstream hazard stall; blocks issue of a new op
read  in  1  load request
write  in  1  store request; wins over read when both are set
noMEM  in  1  ALU result passthrough, writeback enabled
data  in  width  store data / ALU result
address  in  width  byte address; low adrWidth bits used
addressMode  in  3  0=B, 1=H, 2=W, 3=D (only when width=64), 4=BU, 5=HU, 6=WU (only when width=64)
rd  in  rsWidth  destination register
memReq  out  1  bus request
memWe  out  1  1=store
memAddr  out  adrWidth  address aligned to width/8
memWData  out  width  lane-shifted store data
memBe  out  width/8  byte enables
memGnt  in  1  request accepted this cycle
memRValid  in  1  load data valid
memRData  in  width  load data (full aligned beat)
rdOut  out  rsWidth  writeback register
dataOut  out  width  writeback data
WEOut  out  1  writeback enable
stallOut  out  1  hold upstream; inputs stay stable while high
misalignOut  out  1  misalignment trap pulse (present only with MM_MISALIGN_TRAP_EN)

Behaviour:
- Reset (async, rstN=0): state=IDLE; rdOut=0, dataOut=0, WEOut=0, memReq=0, memWe=0, memBe=0, memAddr=0, memWData=0, misalignOut=0. A response in flight when reset asserts is discarded. After reset, memRValid outside RESP is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE, memOp=(read|write) with a legal mode, stallIn=0: capture rd, mode, address low bits, store lanes. Next state REQ. Writeback this edge is a bubble (rdOut=0, dataOut=0, WEOut=0).
- REQ: memReq=1, held with stable address/data/BE until memGnt.
  - memGnt & store: next state IDLE.
  - memGnt & load: next state RESP.
  - memRValid while in REQ is ignored.
- RESP: wait for memRValid. At that edge: rdOut=captured rd, dataOut=extracted/extended lane, WEOut=1. Next state IDLE.
- stallOut (combinational) = stallIn | (memOp & !opDone).
  - opDone = (REQ & memGnt & store) | (RESP & memRValid).
  - Upstream advances on the edge where stallOut=0.
- Minimum occupancy: store 2 cycles, load 3 cycles. There are no stall cycles beyond bus latency.
- Non-memory paths, IDLE, stallIn=0, registered in 1 cycle:
  - noMEM=1: rdOut=rd, dataOut=data, WEOut=1.
  - Otherwise: rdOut=rd, dataOut=data, WEOut=0.
- stallIn=1 in IDLE: bubble, no issue. stallIn has no effect on an in-flight REQ/RESP; that op still completes and writes back.
- Illegal addressMode: treated as a bubble; no bus request, no stall.
- Store lanes:
  - memBe is contiguous, sized 1/2/4/8 bytes, placed at offset address[log2(width/8)-1:0] after alignment.
  - memWData carries data's low bytes shifted to that offset.
- Load extract: select the same lanes from memRData. Sign-extend for B/H/W; zero-extend for BU/HU/WU; no extension for a full-width access.

Optional Feature:
MM_MISALIGN_TRAP_EN.
- Defined: a misaligned access (H with addr[0]=1, W with addr[1:0]≠0, D with addr[2:0]≠0) issues no bus request and does not assert stallOut. The writeback is a bubble and misalignOut pulses high for exactly 1 cycle (registered, at the edge the op would have issued).
- Undefined: the port is absent, and the offending low address bits are forced to zero. The access proceeds aligned, as the previous generation did.

Decomposition:
- Package mm_pkg: addressMode encodings (MODE_B…MODE_WU), FSM state enum, function giving access size in bytes per mode.
- Sub-module mm_lane_align (combinational): memBe/memWData generation and load lane extract/extend. The FSM and registers stay in mm_stage_bus.

Test Plan:
- width=32, noMEM=1, rd=7, data=0x1234 → next cycle rdOut=7, dataOut=0x1234, WEOut=1, stallOut=0 throughout.
- Load B, address 0x000003, memGnt on first REQ cycle, memRValid 2 cycles later with memRData=0x80000000 → memBe=4'b1000, dataOut=0xFFFFFF80, WEOut=1; stallOut high until the memRValid cycle.
- Store H, address 0x000102, data=0xABCD, memGnt delayed 3 cycles → memReq held 3 cycles with stable signals, memBe=4'b1100, memWData=0xABCD0000, WEOut=0.
- Load HU (mode 5), memRData lanes [15:0]=0xFFFE at address 0x10 → dataOut=0x0000FFFE.
- rstN asserted during RESP, then a stray memRValid after release → state IDLE, no WEOut pulse, all outputs 0.
- MM_MISALIGN_TRAP_EN: load W at address 0x000002 → no memReq, misalignOut=1 for 1 cycle, WEOut=0. Without the macro: memAddr=0x000000, memBe=4'hF.
